// File: rtl/pzcorebus_pkg.sv
// Shared pzcorebus types, bus configuration and width helpers.
// Also holds the slicer-specific helpers used by the request slicer.
package pzcorebus_pkg;

   typedef enum logic [1:0] {
      PZCOREBUS_CSR      = 2'd0,
      PZCOREBUS_MEMORY_H = 2'd1,
      PZCOREBUS_MEMORY_L = 2'd2
   } pzcorebus_profile;

   typedef enum logic [3:0] {
      PZCOREBUS_NULL                  = 4'h0,
      PZCOREBUS_MESSAGE               = 4'h1,
      PZCOREBUS_MESSAGE_NON_POSTED    = 4'h3,
      PZCOREBUS_READ                  = 4'h4,
      PZCOREBUS_WRITE                 = 4'h8,
      PZCOREBUS_WRITE_NON_POSTED      = 4'h9,
      PZCOREBUS_BROADCAST             = 4'ha,
      PZCOREBUS_FULL_WRITE            = 4'hc,
      PZCOREBUS_FULL_WRITE_NON_POSTED = 4'hd,
      PZCOREBUS_ATOMIC                = 4'he,
      PZCOREBUS_ATOMIC_NON_POSTED     = 4'hf
   } pzcorebus_command_type;

   typedef struct packed {
      pzcorebus_profile profile;
      int               id_width;
      int               address_width;
      int               data_width;
      int               max_length;
      int               request_info_width;
   } pzcorebus_config;

   localparam pzcorebus_config DEFAULT_CONFIG = '{
      profile:            PZCOREBUS_MEMORY_L,
      id_width:           8,
      address_width:      32,
      data_width:         32,
      max_length:         1024,
      request_info_width: 4
   };

   typedef enum logic {
      SLICER_EMPTY = 1'b0,
      SLICER_BUSY  = 1'b1
   } slicer_state_e;

   // Packed length fields encode max_length as 0, so they need one bit less.
   function automatic int get_length_width(pzcorebus_config bus_config, bit packed_length);
      if (packed_length) begin
         return (bus_config.max_length > 1) ? $clog2(bus_config.max_length) : 1;
      end
      return $clog2(bus_config.max_length + 1);
   endfunction

   function automatic int get_unpacked_length_width(pzcorebus_config bus_config);
      return get_length_width(bus_config, 1'b0);
   endfunction

   function automatic int get_request_info_width(pzcorebus_config bus_config, bit packed_width);
      if (packed_width && (bus_config.request_info_width < 1)) begin
         return 1;
      end
      return bus_config.request_info_width;
   endfunction

   function automatic int get_slice_address_step(pzcorebus_config bus_config, int max_slice);
      return max_slice * bus_config.data_width / 8;
   endfunction

   function automatic bit is_sliceable_command(pzcorebus_command_type mcmd);
      case (mcmd)
         PZCOREBUS_READ,
         PZCOREBUS_WRITE,
         PZCOREBUS_WRITE_NON_POSTED,
         PZCOREBUS_FULL_WRITE,
         PZCOREBUS_FULL_WRITE_NON_POSTED: return 1'b1;
         default:                         return 1'b0;
      endcase
   endfunction

   function automatic bit is_data_command(pzcorebus_command_type mcmd);
      case (mcmd)
         PZCOREBUS_WRITE,
         PZCOREBUS_WRITE_NON_POSTED,
         PZCOREBUS_FULL_WRITE,
         PZCOREBUS_FULL_WRITE_NON_POSTED,
         PZCOREBUS_BROADCAST,
         PZCOREBUS_ATOMIC,
         PZCOREBUS_ATOMIC_NON_POSTED: return 1'b1;
         default:                     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pzcorebus_slice_last_generator.sv
// Counts accepted write-data beats and regenerates mdata_last at every
// slice boundary as well as at the end of the original burst.
module pzcorebus_slice_last_generator #(
   parameter int MAX_SLICE_LENGTH = 4
)(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_beat_valid,
   input  logic i_beat_accept,
   input  logic i_mdata_last,
   output logic o_mdata_last
);

   localparam int            CW         = (MAX_SLICE_LENGTH > 1) ? $clog2(MAX_SLICE_LENGTH) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(MAX_SLICE_LENGTH - 1);

   logic [CW-1:0] r_count;
   logic          w_beat;

   assign w_beat       = i_beat_valid & i_beat_accept;
   assign o_mdata_last = i_mdata_last | (r_count == LAST_COUNT);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (w_beat) begin
         r_count <= o_mdata_last ? '0 : r_count + 1'b1;
      end
   end

endmodule

// File: rtl/pzcorebus_request_slicer.sv
// Splits long MEMORY_L read/write commands into MAX_SLICE_LENGTH-beat slices
// and regenerates per-slice mdata_last on the write-data channel.
module pzcorebus_request_slicer
   import pzcorebus_pkg::*;
#(
   parameter pzcorebus_config BUS_CONFIG       = DEFAULT_CONFIG,
   parameter int              MAX_SLICE_LENGTH = 4,
   localparam int             IDW              = BUS_CONFIG.id_width,
   localparam int             AW               = BUS_CONFIG.address_width,
   localparam int             DW               = BUS_CONFIG.data_width,
   localparam int             BEW              = DW / 8,
   localparam int             LW               = get_length_width(BUS_CONFIG, 1'b1),
   localparam int             IW               = get_request_info_width(BUS_CONFIG, 1'b1)
)(
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_mcmd_valid,
   output logic           o_mcmd_accept,
   input  logic [3:0]     i_mcmd,
   input  logic [IDW-1:0] i_mid,
   input  logic [AW-1:0]  i_maddr,
   input  logic [LW-1:0]  i_mlength,
   input  logic [IW-1:0]  i_minfo,
   input  logic           i_mdata_valid,
   output logic           o_mdata_accept,
   input  logic [DW-1:0]  i_mdata,
   input  logic [BEW-1:0] i_mdata_byteen,
   input  logic           i_mdata_last,
   output logic           o_mcmd_valid,
   input  logic           i_mcmd_accept,
   output logic [3:0]     o_mcmd,
   output logic [IDW-1:0] o_mid,
   output logic [AW-1:0]  o_maddr,
   output logic [LW-1:0]  o_mlength,
   output logic [IW-1:0]  o_minfo,
   output logic           o_mcmd_slice_last,
   output logic           o_mdata_valid,
   input  logic           i_mdata_accept,
   output logic [DW-1:0]  o_mdata,
   output logic [BEW-1:0] o_mdata_byteen,
   output logic           o_mdata_last
);

   localparam int             LUW          = get_unpacked_length_width(BUS_CONFIG);
   localparam logic [LUW-1:0] SLICE_LENGTH = LUW'(MAX_SLICE_LENGTH);
   localparam logic [LUW-1:0] MAX_LENGTH   = LUW'(BUS_CONFIG.max_length);
   localparam logic [AW-1:0]  ADDR_STEP    = AW'(get_slice_address_step(BUS_CONFIG, MAX_SLICE_LENGTH));

   if (BUS_CONFIG.profile != PZCOREBUS_MEMORY_L) begin : g_bad_profile
      $error("pzcorebus_request_slicer: bus profile must be PZCOREBUS_MEMORY_L");
   end

   if ((MAX_SLICE_LENGTH < 1) || (MAX_SLICE_LENGTH > BUS_CONFIG.max_length) ||
       ((MAX_SLICE_LENGTH & (MAX_SLICE_LENGTH - 1)) != 0)) begin : g_bad_slice_length
      $error("pzcorebus_request_slicer: MAX_SLICE_LENGTH must be a power of 2 within max_length");
   end

   slicer_state_e         r_state;
   slicer_state_e         w_next_state;
   pzcorebus_command_type r_mcmd;
   logic [IDW-1:0]        r_mid;
   logic [AW-1:0]         r_maddr;
   logic [LW-1:0]         r_mlength;
   logic [IW-1:0]         r_minfo;
   logic [LUW-1:0]        r_remaining;

   logic                  w_load;
   logic                  w_advance;
   logic                  w_sliceable;
   logic                  w_slice_last;
   logic [LUW-1:0]        w_in_length;
   logic [LUW-1:0]        w_slice_length;

   assign w_in_length    = (i_mlength == '0) ? MAX_LENGTH : LUW'(i_mlength);
   assign w_sliceable    = is_sliceable_command(r_mcmd);
   assign w_slice_last   = !w_sliceable || (r_remaining <= SLICE_LENGTH);
   assign w_slice_length = (r_remaining <= SLICE_LENGTH) ? r_remaining : SLICE_LENGTH;

   // Command outputs come only from registers; the accept is the sole combinational path.
   assign o_mcmd_valid      = (r_state == SLICER_BUSY);
   assign o_mcmd            = r_mcmd;
   assign o_mid             = r_mid;
   assign o_maddr           = r_maddr;
   assign o_minfo           = r_minfo;
   assign o_mcmd_slice_last = w_slice_last;
   assign o_mlength         = !w_sliceable                  ? r_mlength :
                              (w_slice_length == MAX_LENGTH) ? '0        :
                                                               w_slice_length[LW-1:0];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= SLICER_EMPTY;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      w_next_state  = r_state;
      o_mcmd_accept = 1'b0;
      w_load        = 1'b0;
      w_advance     = 1'b0;
      case (r_state)
         SLICER_EMPTY: begin
            o_mcmd_accept = 1'b1;
            if (i_mcmd_valid) begin
               w_load       = 1'b1;
               w_next_state = SLICER_BUSY;
            end
         end
         SLICER_BUSY: begin
            if (i_mcmd_accept) begin
               if (w_slice_last) begin
                  o_mcmd_accept = 1'b1;
                  w_load        = i_mcmd_valid;
                  w_next_state  = i_mcmd_valid ? SLICER_BUSY : SLICER_EMPTY;
               end else begin
                  w_advance = 1'b1;
               end
            end
         end
         default: w_next_state = SLICER_EMPTY;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mcmd      <= PZCOREBUS_NULL;
         r_mid       <= '0;
         r_maddr     <= '0;
         r_mlength   <= '0;
         r_minfo     <= '0;
         r_remaining <= '0;
      end else if (w_load) begin
         r_mcmd      <= pzcorebus_command_type'(i_mcmd);
         r_mid       <= i_mid;
         r_maddr     <= i_maddr;
         r_mlength   <= i_mlength;
         r_minfo     <= i_minfo;
         r_remaining <= w_in_length;
      end else if (w_advance) begin
         r_remaining <= r_remaining - SLICE_LENGTH;
         r_maddr     <= r_maddr + ADDR_STEP;
      end
   end

   // Write data is never gated by command progress; slicing preserves order.
   assign o_mdata_valid  = i_mdata_valid;
   assign o_mdata_accept = i_mdata_accept;
   assign o_mdata        = i_mdata;
   assign o_mdata_byteen = i_mdata_byteen;

   pzcorebus_slice_last_generator #(
      .MAX_SLICE_LENGTH (MAX_SLICE_LENGTH)
   ) u_slice_last (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_beat_valid  (i_mdata_valid),
      .i_beat_accept (i_mdata_accept),
      .i_mdata_last  (i_mdata_last),
      .o_mdata_last  (o_mdata_last)
   );

`ifndef SYNTHESIS
   logic [LUW-1:0] r_sim_beats;
   logic [LUW-1:0] r_sim_length;
   logic           r_sim_cmd_seen;
   logic           w_sim_cmd_load;
   logic [LUW-1:0] w_sim_length;

   assign w_sim_cmd_load = i_mcmd_valid && o_mcmd_accept &&
                           is_data_command(pzcorebus_command_type'(i_mcmd));
   assign w_sim_length   = w_sim_cmd_load ? w_in_length : r_sim_length;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sim_beats    <= '0;
         r_sim_length   <= '0;
         r_sim_cmd_seen <= 1'b0;
      end else begin
         if (w_sim_cmd_load) begin
            r_sim_length   <= w_in_length;
            r_sim_cmd_seen <= 1'b1;
         end
         if (i_mdata_valid && i_mdata_accept) begin
            r_sim_beats <= i_mdata_last ? '0 : r_sim_beats + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst_n && i_mdata_valid && i_mdata_accept && i_mdata_last &&
          (r_sim_cmd_seen || w_sim_cmd_load)) begin
         assert (r_sim_beats + 1'b1 == w_sim_length)
            else $error("pzcorebus_request_slicer: mdata_last after %0d beats, command length %0d",
                        r_sim_beats + 1'b1, w_sim_length);
      end
   end
`endif

endmodule

// File: tb/tb_pzcorebus_request_slicer.sv
// Directed bench for pzcorebus_request_slicer with hand-computed expectations
// (32-bit data and address, max_length 1024, MAX_SLICE_LENGTH 4).
module tb_pzcorebus_request_slicer;
   import pzcorebus_pkg::*;

   localparam pzcorebus_config CFG = DEFAULT_CONFIG;
   localparam int IDW = CFG.id_width;
   localparam int AW  = CFG.address_width;
   localparam int DW  = CFG.data_width;
   localparam int BEW = DW / 8;
   localparam int LW  = get_length_width(CFG, 1'b1);
   localparam int IW  = get_request_info_width(CFG, 1'b1);

   logic           i_clk;
   logic           i_rst_n;
   logic           i_mcmd_valid;
   logic           o_mcmd_accept;
   logic [3:0]     i_mcmd;
   logic [IDW-1:0] i_mid;
   logic [AW-1:0]  i_maddr;
   logic [LW-1:0]  i_mlength;
   logic [IW-1:0]  i_minfo;
   logic           i_mdata_valid;
   logic           o_mdata_accept;
   logic [DW-1:0]  i_mdata;
   logic [BEW-1:0] i_mdata_byteen;
   logic           i_mdata_last;
   logic           o_mcmd_valid;
   logic           i_mcmd_accept;
   logic [3:0]     o_mcmd;
   logic [IDW-1:0] o_mid;
   logic [AW-1:0]  o_maddr;
   logic [LW-1:0]  o_mlength;
   logic [IW-1:0]  o_minfo;
   logic           o_mcmd_slice_last;
   logic           o_mdata_valid;
   logic           i_mdata_accept;
   logic [DW-1:0]  o_mdata;
   logic [BEW-1:0] o_mdata_byteen;
   logic           o_mdata_last;

   int n_vectors     = 0;
   int n_miscompares = 0;

   pzcorebus_request_slicer #(
      .BUS_CONFIG       (CFG),
      .MAX_SLICE_LENGTH (4)
   ) dut (
      .i_clk             (i_clk),
      .i_rst_n           (i_rst_n),
      .i_mcmd_valid      (i_mcmd_valid),
      .o_mcmd_accept     (o_mcmd_accept),
      .i_mcmd            (i_mcmd),
      .i_mid             (i_mid),
      .i_maddr           (i_maddr),
      .i_mlength         (i_mlength),
      .i_minfo           (i_minfo),
      .i_mdata_valid     (i_mdata_valid),
      .o_mdata_accept    (o_mdata_accept),
      .i_mdata           (i_mdata),
      .i_mdata_byteen    (i_mdata_byteen),
      .i_mdata_last      (i_mdata_last),
      .o_mcmd_valid      (o_mcmd_valid),
      .i_mcmd_accept     (i_mcmd_accept),
      .o_mcmd            (o_mcmd),
      .o_mid             (o_mid),
      .o_maddr           (o_maddr),
      .o_mlength         (o_mlength),
      .o_minfo           (o_minfo),
      .o_mcmd_slice_last (o_mcmd_slice_last),
      .o_mdata_valid     (o_mdata_valid),
      .i_mdata_accept    (i_mdata_accept),
      .o_mdata           (o_mdata),
      .o_mdata_byteen    (o_mdata_byteen),
      .o_mdata_last      (o_mdata_last)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_vectors++;
      assert (observed === expected) else begin
         n_miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic next_cycle();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_cmd(input pzcorebus_command_type cmd, input logic [IDW-1:0] id,
                           input logic [AW-1:0] addr, input logic [LW-1:0] len);
      i_mcmd_valid = 1'b1;
      i_mcmd       = cmd;
      i_mid        = id;
      i_maddr      = addr;
      i_mlength    = len;
      i_minfo      = IW'(id);
      #1;
      check("cmd_accept_when_empty", o_mcmd_accept, 1'b1);
      next_cycle();
      i_mcmd_valid = 1'b0;
   endtask

   // Expects i_mcmd_accept high, so accept mirrors slice_last.
   task automatic expect_slice(input string tag, input pzcorebus_command_type cmd,
                               input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                               input logic [LW-1:0] len, input logic slast);
      #1;
      check({tag, "_valid"},  o_mcmd_valid, 1'b1);
      check({tag, "_cmd"},    o_mcmd, cmd);
      check({tag, "_id"},     o_mid, id);
      check({tag, "_info"},   o_minfo, IW'(id));
      check({tag, "_addr"},   o_maddr, addr);
      check({tag, "_len"},    o_mlength, len);
      check({tag, "_slast"},  o_mcmd_slice_last, slast);
      check({tag, "_accept"}, o_mcmd_accept, slast);
      next_cycle();
   endtask

   task automatic expect_idle(input string tag);
      #1;
      check({tag, "_idle_valid"},  o_mcmd_valid, 1'b0);
      check({tag, "_idle_accept"}, o_mcmd_accept, 1'b1);
      next_cycle();
   endtask

   task automatic drive_beat(input string tag, input logic [DW-1:0] data, input logic last,
                             input logic accept, input logic exp_last);
      i_mdata_valid  = 1'b1;
      i_mdata        = data;
      i_mdata_byteen = BEW'(data);
      i_mdata_last   = last;
      i_mdata_accept = accept;
      #1;
      check({tag, "_dvalid"},  o_mdata_valid, 1'b1);
      check({tag, "_data"},    o_mdata, data);
      check({tag, "_byteen"},  o_mdata_byteen, BEW'(data));
      check({tag, "_daccept"}, o_mdata_accept, accept);
      check({tag, "_dlast"},   o_mdata_last, exp_last);
      next_cycle();
      i_mdata_valid  = 1'b0;
      i_mdata_last   = 1'b0;
      i_mdata_accept = 1'b1;
   endtask

   initial begin
      i_rst_n        = 1'b0;
      i_mcmd_valid   = 1'b0;
      i_mcmd         = '0;
      i_mid          = '0;
      i_maddr        = '0;
      i_mlength      = '0;
      i_minfo        = '0;
      i_mdata_valid  = 1'b0;
      i_mdata        = '0;
      i_mdata_byteen = '0;
      i_mdata_last   = 1'b0;
      i_mcmd_accept  = 1'b1;
      i_mdata_accept = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      check("rst_valid",  o_mcmd_valid, 1'b0);
      check("rst_accept", o_mcmd_accept, 1'b1);
      check("rst_addr",   o_maddr, '0);
      check("rst_len",    o_mlength, '0);
      check("rst_id",     o_mid, '0);
      check("rst_cmd",    o_mcmd, '0);
      check("rst_dlast",  o_mdata_last, 1'b0);
      i_rst_n = 1'b1;
      next_cycle();

      // Long read split into 4 + 4 + 2 beats.
      send_cmd(PZCOREBUS_READ, 8'd5, 32'h1000, 10'd10);
      expect_slice("t1_s0", PZCOREBUS_READ, 8'd5, 32'h1000, 10'd4, 1'b0);
      expect_slice("t1_s1", PZCOREBUS_READ, 8'd5, 32'h1010, 10'd4, 1'b0);
      expect_slice("t1_s2", PZCOREBUS_READ, 8'd5, 32'h1020, 10'd2, 1'b1);
      expect_idle("t1");

      // Downstream stall during slice 2 must freeze the command fields.
      send_cmd(PZCOREBUS_READ, 8'd5, 32'h1000, 10'd10);
      expect_slice("t5_s0", PZCOREBUS_READ, 8'd5, 32'h1000, 10'd4, 1'b0);
      i_mcmd_accept = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t5_stall_valid",  o_mcmd_valid, 1'b1);
         check("t5_stall_addr",   o_maddr, 32'h1010);
         check("t5_stall_len",    o_mlength, 10'd4);
         check("t5_stall_accept", o_mcmd_accept, 1'b0);
         next_cycle();
      end
      i_mcmd_accept = 1'b1;
      expect_slice("t5_s1", PZCOREBUS_READ, 8'd5, 32'h1010, 10'd4, 1'b0);
      expect_slice("t5_s2", PZCOREBUS_READ, 8'd5, 32'h1020, 10'd2, 1'b1);
      expect_idle("t5");

      // Write of 6 beats: slices 4 + 2, regenerated last on beats 4 and 6.
      send_cmd(PZCOREBUS_WRITE, 8'd2, 32'h2000, 10'd6);
      expect_slice("t2_s0", PZCOREBUS_WRITE, 8'd2, 32'h2000, 10'd4, 1'b0);
      expect_slice("t2_s1", PZCOREBUS_WRITE, 8'd2, 32'h2010, 10'd2, 1'b1);
      expect_idle("t2");
      drive_beat("t2_b1",       32'hA000_0001, 1'b0, 1'b1, 1'b0);
      drive_beat("t2_b2",       32'hA000_0002, 1'b0, 1'b1, 1'b0);
      drive_beat("t2_b3_stall", 32'hA000_0003, 1'b0, 1'b0, 1'b0);
      drive_beat("t2_b3",       32'hA000_0003, 1'b0, 1'b1, 1'b0);
      drive_beat("t2_b4",       32'hA000_0004, 1'b0, 1'b1, 1'b1);
      drive_beat("t2_b5",       32'hA000_0005, 1'b0, 1'b1, 1'b0);
      drive_beat("t2_b6",       32'hA000_0006, 1'b1, 1'b1, 1'b1);

      // Length field 0 means 1024 beats: 256 slices of 4, 16-byte address steps.
      send_cmd(PZCOREBUS_READ, 8'd7, 32'h8000, 10'd0);
      for (int i = 0; i < 256; i++) begin
         expect_slice("t3", PZCOREBUS_READ, 8'd7, 32'h8000 + 32'(16 * i), 10'd4, (i == 255));
      end
      expect_idle("t3");

      // Message passes unsliced; the next read is loaded in the same accept cycle.
      send_cmd(PZCOREBUS_MESSAGE, 8'd3, 32'h3000, 10'd8);
      i_mcmd_valid = 1'b1;
      i_mcmd       = PZCOREBUS_READ;
      i_mid        = 8'd4;
      i_maddr      = 32'h4000;
      i_mlength    = 10'd3;
      i_minfo      = IW'(8'd4);
      #1;
      check("t4_msg_valid",  o_mcmd_valid, 1'b1);
      check("t4_msg_cmd",    o_mcmd, PZCOREBUS_MESSAGE);
      check("t4_msg_addr",   o_maddr, 32'h3000);
      check("t4_msg_len",    o_mlength, 10'd8);
      check("t4_msg_slast",  o_mcmd_slice_last, 1'b1);
      check("t4_msg_accept", o_mcmd_accept, 1'b1);
      next_cycle();
      i_mcmd_valid = 1'b0;
      expect_slice("t4_rd", PZCOREBUS_READ, 8'd4, 32'h4000, 10'd3, 1'b1);
      expect_idle("t4");

      // Reset in the middle of a sliced read, with the beat counter at 2.
      drive_beat("t6_pre_b1", 32'hB000_0001, 1'b0, 1'b1, 1'b0);
      drive_beat("t6_pre_b2", 32'hB000_0002, 1'b0, 1'b1, 1'b0);
      send_cmd(PZCOREBUS_READ, 8'd5, 32'h1000, 10'd10);
      expect_slice("t6_s0", PZCOREBUS_READ, 8'd5, 32'h1000, 10'd4, 1'b0);
      i_rst_n = 1'b0;
      #1;
      check("t6_rst_valid",  o_mcmd_valid, 1'b0);
      check("t6_rst_accept", o_mcmd_accept, 1'b1);
      check("t6_rst_addr",   o_maddr, '0);
      check("t6_rst_len",    o_mlength, '0);
      next_cycle();
      i_rst_n = 1'b1;
      next_cycle();
      send_cmd(PZCOREBUS_READ, 8'd6, 32'h5000, 10'd2);
      expect_slice("t6_rd", PZCOREBUS_READ, 8'd6, 32'h5000, 10'd2, 1'b1);
      expect_idle("t6_rd");
      send_cmd(PZCOREBUS_WRITE, 8'd6, 32'h6000, 10'd4);
      expect_slice("t6_wr", PZCOREBUS_WRITE, 8'd6, 32'h6000, 10'd4, 1'b1);
      expect_idle("t6_wr");
      drive_beat("t6_b1", 32'hC000_0001, 1'b0, 1'b1, 1'b0);
      drive_beat("t6_b2", 32'hC000_0002, 1'b0, 1'b1, 1'b0);
      drive_beat("t6_b3", 32'hC000_0003, 1'b0, 1'b1, 1'b0);
      drive_beat("t6_b4", 32'hC000_0004, 1'b1, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
